// File: rtl/mission_sequencer.sv
// Mission sequencer: snapshots sensor inputs, requests a stage-checker verdict,
// and advances the mission state with retry and timeout protection.
module mission_sequencer #(
  parameter int unsigned ALT_MAX   = 768,
  parameter int unsigned TIMEOUT   = 15,
  parameter int unsigned RETRY_MAX = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_req,
  input  logic [9:0] altitude_in,
  input  logic       temp_in,
  input  logic       rad_in,
  input  logic       oxygen_in,
  input  logic       life_in,
  output logic [9:0] chk_altitude,
  output logic       chk_temp,
  output logic       chk_rad,
  output logic       chk_oxygen,
  output logic       chk_life,
  output logic       chk_scaled,
  output logic       chk_valid,
  input  logic       chk_done,
  input  logic [1:0] chk_next,
  output logic [1:0] mission_state,
  output logic       busy,
  output logic       timeout_err
);

  localparam int unsigned ALT_W = 10;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned RTY_W = 3;

  localparam logic [1:0] MS_HOLD_PAD = 2'b00;
  localparam logic [1:0] MS_ASCENT   = 2'b01;
  localparam logic [1:0] MS_DEST     = 2'b10;
  localparam logic [1:0] MS_ABORT    = 2'b11;

  localparam logic [1:0] V_PROCEED = 2'b00;
  localparam logic [1:0] V_ABORT   = 2'b11;

  localparam logic [ALT_W-1:0] ALT_LIMIT = ALT_W'(ALT_MAX);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [RTY_W-1:0] RTY_LIMIT = RTY_W'(RETRY_MAX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SNAP,
    S_WAIT,
    S_COMMIT
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [RTY_W-1:0]   retry_q, retry_d;
  logic [RTY_W-1:0]   retry_inc;
  logic [1:0]         verdict_q, verdict_d;
  logic [1:0]         mission_q, mission_d;
  logic               timeout_err_q, timeout_err_d;
  logic [ALT_W-1:0]   chk_alt_q, chk_alt_d;
  logic               chk_temp_q, chk_temp_d;
  logic               chk_rad_q, chk_rad_d;
  logic               chk_oxygen_q, chk_oxygen_d;
  logic               chk_life_q, chk_life_d;
  logic               chk_scaled_q, chk_scaled_d;
  logic               chk_valid_q, chk_valid_d;
  logic               busy_q, busy_d;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      wait_cnt_q    <= '0;
      retry_q       <= '0;
      verdict_q     <= '0;
      mission_q     <= MS_HOLD_PAD;
      timeout_err_q <= 1'b0;
      chk_alt_q     <= '0;
      chk_temp_q    <= 1'b0;
      chk_rad_q     <= 1'b0;
      chk_oxygen_q  <= 1'b0;
      chk_life_q    <= 1'b0;
      chk_scaled_q  <= 1'b0;
      chk_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      retry_q       <= retry_d;
      verdict_q     <= verdict_d;
      mission_q     <= mission_d;
      timeout_err_q <= timeout_err_d;
      chk_alt_q     <= chk_alt_d;
      chk_temp_q    <= chk_temp_d;
      chk_rad_q     <= chk_rad_d;
      chk_oxygen_q  <= chk_oxygen_d;
      chk_life_q    <= chk_life_d;
      chk_scaled_q  <= chk_scaled_d;
      chk_valid_q   <= chk_valid_d;
      busy_q        <= busy_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    retry_d       = retry_q;
    retry_inc     = retry_q + RTY_W'(1);
    verdict_d     = verdict_q;
    mission_d     = mission_q;
    timeout_err_d = timeout_err_q;
    chk_alt_d     = chk_alt_q;
    chk_temp_d    = chk_temp_q;
    chk_rad_d     = chk_rad_q;
    chk_oxygen_d  = chk_oxygen_q;
    chk_life_d    = chk_life_q;
    chk_scaled_d  = chk_scaled_q;

    case (state_q)
      S_IDLE: begin
        if (sample_req && (mission_q != MS_ABORT)) begin
          state_d = S_SNAP;
        end
      end
      S_SNAP: begin
        if (altitude_in > ALT_LIMIT) begin
          chk_alt_d    = altitude_in >> 1;
          chk_scaled_d = 1'b1;
        end else begin
          chk_alt_d    = altitude_in;
          chk_scaled_d = 1'b0;
        end
        chk_temp_d   = temp_in;
        chk_rad_d    = rad_in;
        chk_oxygen_d = oxygen_in;
        chk_life_d   = life_in;
        wait_cnt_d   = '0;
        state_d      = S_WAIT;
      end
      S_WAIT: begin
        wait_cnt_d = wait_cnt_q + CNT_W'(1);
        // A verdict arriving on the final wait cycle still beats the timeout
        if (chk_done) begin
          verdict_d = chk_next;
          state_d   = S_COMMIT;
        end else if (wait_cnt_q == WAIT_LAST) begin
          timeout_err_d = 1'b1;
          mission_d     = MS_ABORT;
          state_d       = S_IDLE;
        end
      end
      S_COMMIT: begin
        if (verdict_q == V_PROCEED) begin
          retry_d = '0;
          if (mission_q == MS_HOLD_PAD) begin
            mission_d = MS_ASCENT;
          end else if (mission_q == MS_ASCENT) begin
            mission_d = MS_DEST;
          end
        end else if (verdict_q == V_ABORT) begin
          mission_d = MS_ABORT;
        end else begin
          retry_d = retry_inc;
          if (retry_inc == RTY_LIMIT) begin
            mission_d = MS_ABORT;
          end
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    chk_valid_d = (state_d == S_WAIT);
    busy_d      = (state_d != S_IDLE);
  end

  assign chk_altitude  = chk_alt_q;
  assign chk_temp      = chk_temp_q;
  assign chk_rad       = chk_rad_q;
  assign chk_oxygen    = chk_oxygen_q;
  assign chk_life      = chk_life_q;
  assign chk_scaled    = chk_scaled_q;
  assign chk_valid     = chk_valid_q;
  assign mission_state = mission_q;
  assign busy          = busy_q;
  assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_mission_sequencer.sv
// Directed self-checking bench for mission_sequencer.
module tb_mission_sequencer;

  logic       clk;
  logic       rst;
  logic       sample_req;
  logic [9:0] altitude_in;
  logic       temp_in, rad_in, oxygen_in, life_in;
  logic [9:0] chk_altitude;
  logic       chk_temp, chk_rad, chk_oxygen, chk_life;
  logic       chk_scaled, chk_valid;
  logic       chk_done;
  logic [1:0] chk_next;
  logic [1:0] mission_state;
  logic       busy, timeout_err;

  int n_tests;
  int n_fail;

  mission_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .sample_req   (sample_req),
    .altitude_in  (altitude_in),
    .temp_in      (temp_in),
    .rad_in       (rad_in),
    .oxygen_in    (oxygen_in),
    .life_in      (life_in),
    .chk_altitude (chk_altitude),
    .chk_temp     (chk_temp),
    .chk_rad      (chk_rad),
    .chk_oxygen   (chk_oxygen),
    .chk_life     (chk_life),
    .chk_scaled   (chk_scaled),
    .chk_valid    (chk_valid),
    .chk_done     (chk_done),
    .chk_next     (chk_next),
    .mission_state(mission_state),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Pulse sample_req; returns during the SNAP cycle
  task automatic start(input logic [9:0] alt, input logic [3:0] flags);
    altitude_in = alt;
    {temp_in, rad_in, oxygen_in, life_in} = flags;
    sample_req = 1'b1;
    tick();
    sample_req = 1'b0;
  endtask

  // Full round: verdict given after `delay` silent WAIT cycles
  task automatic round(input string tag, input logic [9:0] alt, input logic [3:0] flags,
                       input logic [9:0] exp_alt, input logic exp_scaled,
                       input int delay, input logic [1:0] nxt, input logic [1:0] exp_ms);
    start(alt, flags);
    tick();
    check({tag, ".valid"}, 32'(chk_valid), 32'd1);
    check({tag, ".alt"}, 32'(chk_altitude), 32'(exp_alt));
    check({tag, ".scaled"}, 32'(chk_scaled), 32'(exp_scaled));
    check({tag, ".flags"}, 32'({chk_temp, chk_rad, chk_oxygen, chk_life}), 32'(flags));
    repeat (delay) tick();
    chk_done = 1'b1;
    chk_next = nxt;
    tick();
    chk_done = 1'b0;
    chk_next = 2'b00;
    tick();
    check({tag, ".ms"}, 32'(mission_state), 32'(exp_ms));
    check({tag, ".busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int vcnt;
    int guard;
    n_tests = 0;
    n_fail = 0;
    rst = 1'b0;
    sample_req = 1'b0;
    altitude_in = '0;
    {temp_in, rad_in, oxygen_in, life_in} = 4'b0;
    chk_done = 1'b0;
    chk_next = 2'b00;

    do_reset();
    check("rst.ms", 32'(mission_state), 32'd0);
    check("rst.valid", 32'(chk_valid), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.tmo", 32'(timeout_err), 32'd0);
    check("rst.alt", 32'(chk_altitude), 32'd0);
    check("rst.scaled", 32'(chk_scaled), 32'd0);

    // Stray verdict in IDLE is ignored
    chk_done = 1'b1;
    tick();
    chk_done = 1'b0;
    check("idle_done.ms", 32'(mission_state), 32'd0);
    check("idle_done.busy", 32'(busy), 32'd0);

    // Altitude scaling and PROCEED progression
    round("p1", 10'd865, 4'b1010, 10'd432, 1'b1, 0, 2'b00, 2'b01);
    round("p2", 10'd768, 4'b0101, 10'd768, 1'b0, 0, 2'b00, 2'b10);
    round("p3", 10'd100, 4'b1111, 10'd100, 1'b0, 0, 2'b00, 2'b10);

    // Three HOLDs force ABORT
    do_reset();
    round("h1", 10'd769, 4'b0001, 10'd384, 1'b1, 0, 2'b01, 2'b00);
    round("h2", 10'd5, 4'b0010, 10'd5, 1'b0, 0, 2'b10, 2'b00);
    round("h3", 10'd1023, 4'b0100, 10'd511, 1'b1, 0, 2'b01, 2'b11);

    // PROCEED clears the retry count
    do_reset();
    round("r1", 10'd1, 4'b0, 10'd1, 1'b0, 0, 2'b01, 2'b00);
    round("r2", 10'd2, 4'b0, 10'd2, 1'b0, 0, 2'b10, 2'b00);
    round("r3", 10'd3, 4'b0, 10'd3, 1'b0, 0, 2'b00, 2'b01);
    round("r4", 10'd4, 4'b0, 10'd4, 1'b0, 0, 2'b01, 2'b01);
    round("r5", 10'd6, 4'b0, 10'd6, 1'b0, 0, 2'b01, 2'b01);
    round("r6", 10'd7, 4'b0, 10'd7, 1'b0, 0, 2'b01, 2'b11);

    // Timeout: valid for 15 cycles, then ABORT with sticky error
    do_reset();
    start(10'd50, 4'b0);
    vcnt = 0;
    guard = 0;
    do begin
      tick();
      if (chk_valid) vcnt++;
      guard++;
    end while (busy && guard < 40);
    check("tmo.guard", 32'(guard < 40), 32'd1);
    check("tmo.vcnt", 32'(vcnt), 32'd15);
    check("tmo.err", 32'(timeout_err), 32'd1);
    check("tmo.ms", 32'(mission_state), 32'd3);
    start(10'd50, 4'b0);
    check("tmo.ign1", 32'(busy), 32'd0);
    tick();
    check("tmo.ign2", 32'(busy), 32'd0);
    check("tmo.ms2", 32'(mission_state), 32'd3);

    // Verdict on the final wait cycle wins over the timeout
    do_reset();
    round("edge", 10'd768, 4'b0, 10'd768, 1'b0, 14, 2'b00, 2'b01);
    check("edge.err", 32'(timeout_err), 32'd0);

    // ABORT verdict is terminal
    round("ab", 10'd10, 4'b0, 10'd10, 1'b0, 2, 2'b11, 2'b11);
    start(10'd10, 4'b0);
    check("ab.ign", 32'(busy), 32'd0);

    // Reset mid-WAIT discards the round
    do_reset();
    round("pre", 10'd20, 4'b0, 10'd20, 1'b0, 0, 2'b00, 2'b01);
    start(10'd20, 4'b0);
    tick();
    tick();
    check("mid.valid_pre", 32'(chk_valid), 32'd1);
    rst = 1'b1;
    chk_done = 1'b1;
    tick();
    rst = 1'b0;
    chk_done = 1'b0;
    check("mid.valid", 32'(chk_valid), 32'd0);
    check("mid.busy", 32'(busy), 32'd0);
    check("mid.ms", 32'(mission_state), 32'd0);
    check("mid.err", 32'(timeout_err), 32'd0);
    tick();
    check("mid.ms2", 32'(mission_state), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mission_sequencer.md
MISSION_SEQUENCER -- requirements
Module: mission_sequencer

Interface
REQ-001 Parameter ALT_MAX, default 10'b1100000000 (768), altitude ceiling above which the snapshot altitude is halved.
REQ-002 Parameter TIMEOUT, default 15, maximum cycles to wait for a stage-checker verdict (range 1..255).
REQ-003 Parameter RETRY_MAX, default 3, consecutive HOLD verdicts tolerated before forcing ABORT (range 1..7).
REQ-004 clk  input  1  single clock; all logic SHALL be updated on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 sample_req  input  1  one-cycle pulse that starts one evaluation round.
REQ-007 altitude_in  input  10  raw altitude sensor reading.
REQ-008 temp_in, rad_in, oxygen_in, life_in  input  1 each  raw sensor status flags.
REQ-009 chk_altitude  output  10  registered altitude snapshot presented to the stage checker.
REQ-010 chk_temp, chk_rad, chk_oxygen, chk_life  output  1 each  registered flag snapshot.
REQ-011 chk_scaled  output  1  high when chk_altitude was halved.
REQ-012 chk_valid  output  1  snapshot valid, checker request.
REQ-013 chk_done  input  1  checker verdict strobe.
REQ-014 chk_next  input  2  checker verdict: 00 PROCEED, 11 ABORT, 01/10 HOLD.
REQ-015 mission_state  output  2  00 HOLD_PAD, 01 ASCENT, 10 DESTINATION, 11 ABORT.
REQ-016 busy  output  1  high whenever the control FSM is not IDLE.
REQ-017 timeout_err  output  1  sticky flag, set on verdict timeout.

Function
REQ-018 The control FSM SHALL have states IDLE, SNAP, WAIT and COMMIT.
REQ-019 IDLE: sample_req=1 and mission_state!=ABORT SHALL move the FSM to SNAP; sample_req SHALL be ignored in every other state and while in ABORT.
REQ-020 SNAP, one cycle: all chk_* snapshot registers SHALL load from the *_in inputs, and the FSM SHALL go to WAIT.
REQ-021 Altitude snapshot: altitude_in > ALT_MAX (unsigned) SHALL give chk_altitude = altitude_in >> 1 and chk_scaled=1; otherwise chk_altitude = altitude_in and chk_scaled=0.
REQ-022 Snapshot registers SHALL hold their values from SNAP until the next SNAP.
REQ-023 chk_valid SHALL be 1 exactly while in WAIT, which begins the cycle after SNAP.
REQ-024 WAIT: an 8-bit wait counter SHALL clear on entry and increment once per cycle.
REQ-025 WAIT: chk_done=1 SHALL latch chk_next and move the FSM to COMMIT; chk_done outside WAIT SHALL be ignored.
REQ-026 WAIT: if the counter reaches TIMEOUT with chk_done=0, timeout_err SHALL set, mission_state SHALL become ABORT and the FSM SHALL return to IDLE.
REQ-027 If chk_done=1 in the same cycle the counter reaches TIMEOUT, the verdict SHALL win and no timeout SHALL occur.
REQ-028 COMMIT, one cycle, with a latched PROCEED: mission_state SHALL advance HOLD_PAD->ASCENT->DESTINATION, DESTINATION SHALL hold, and the retry counter SHALL clear.
REQ-029 COMMIT with a latched ABORT: mission_state SHALL become ABORT.
REQ-030 COMMIT with a latched HOLD: the 3-bit retry counter SHALL increment; if it then equals RETRY_MAX, mission_state SHALL become ABORT, otherwise it SHALL be unchanged.
REQ-031 COMMIT SHALL always return the FSM to IDLE.
REQ-032 ABORT SHALL be terminal and SHALL be left only by rst.
REQ-033 Latency from sample_req to the mission_state update SHALL be 3 cycles plus the WAIT duration; a verdict in the first WAIT cycle gives mission_state updated 4 cycles after sample_req.

Reset
REQ-034 rst=1 SHALL, at the next clk edge, set FSM=IDLE, mission_state=00, chk_valid=0, busy=0, timeout_err=0, the retry counter to 0, the wait counter to 0, and all snapshot registers to 0.
REQ-035 rst SHALL take priority over every event, including mid-WAIT and during COMMIT, and SHALL discard any in-flight verdict.

Verification
REQ-036 Bench SHALL apply sample_req with altitude_in=10'b1101100001 (865) -> chk_altitude=10'b0110110000 (432), chk_scaled=1; altitude_in=768 -> chk_altitude=768, chk_scaled=0.
REQ-037 Bench SHALL run three rounds, each with chk_done in the first WAIT cycle and chk_next=00 -> mission_state sequence 01, 10, 10.
REQ-038 Bench SHALL run three consecutive rounds with chk_next=01 and RETRY_MAX=3 -> mission_state unchanged after rounds 1 and 2, and 11 after round 3.
REQ-039 Bench SHALL hold chk_done=0 for a full round -> chk_valid high for exactly 15 cycles, then timeout_err=1 and mission_state=11; a later sample_req SHALL be ignored.
REQ-040 Bench SHALL raise chk_done=1 with chk_next=00 in the same cycle the wait counter reaches TIMEOUT -> state advances and timeout_err stays 0.
REQ-041 Bench SHALL assert rst during WAIT -> next cycle chk_valid=0, busy=0, mission_state=00, timeout_err=0.
